// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digits needed to cover the operand width.
    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Digit counter width: clog2(NDIG), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
        int unsigned n;
        n = ndig(width, digit);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder; c_msb is the carry into the top bit.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder processing DIGIT bits per clock, LSB digit first.
// Optional subtract mode (sub port) is enabled by defining ADDSUB_EN.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
`ifdef ADDSUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int unsigned NDIG  = ndig(WIDTH, DIGIT);
    localparam int unsigned CNT_W = cnt_width(WIDTH, DIGIT);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   acc;
    logic               cy;

    logic [DIGIT-1:0]   dsum;
    logic               dcout;
    logic               dcmsb;
    logic [WIDTH-1:0]   acc_next;
    logic               last_digit;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (opa[DIGIT-1:0]),
        .y     (opb[DIGIT-1:0]),
        .cin   (cy),
        .s     (dsum),
        .cout  (dcout),
        .c_msb (dcmsb)
    );

    // New digit enters at the top; after NDIG shifts the result is aligned.
    assign acc_next   = WIDTH'({dsum, acc} >> DIGIT);
    assign last_digit = (cnt == CNT_W'(NDIG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            cy       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa  <= a;
                        cnt  <= '0;
                        busy <= 1'b1;
                        state <= RUN;
`ifdef ADDSUB_EN
                        opb <= sub ? ~b : b;
                        cy  <= sub ? 1'b1 : carryin;
`else
                        opb <= b;
                        cy  <= carryin;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cy  <= dcout;
                    opa <= opa >> DIGIT;
                    opb <= opb >> DIGIT;
                    cnt <= cnt + CNT_W'(1);
                    if (last_digit) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= acc_next;
                        carryout <= dcout;
                        overflow <= dcout ^ dcmsb;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench: 16/4 instance plus an 8/8 single-digit instance.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        carryin;
    logic        sub;
    logic        busy, done, carryout, overflow;
    logic [15:0] sum;

    logic        start8;
    logic [7:0]  a8, b8, sum8;
    logic        cin8, busy8, done8, co8, ov8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carryin(carryin),
`ifdef ADDSUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .carryout(carryout), .overflow(overflow)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carryin(cin8),
`ifdef ADDSUB_EN
        .sub(1'b0),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .carryout(co8), .overflow(ov8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_op,
                         input logic tc, input logic ts,
                         input logic [15:0] es, input logic eco, input logic eov);
        logic [15:0] held;
        int cyc;
        held    = sum;
        a       = ta;
        b       = tb_op;
        carryin = tc;
        sub     = ts;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
        check({tag, " busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) check({tag, " hold"}, 32'(sum), 32'(held));
        end
        check({tag, " latency"}, 32'(cyc), 32'd4);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " carryout"}, 32'(carryout), 32'(eco));
        check({tag, " overflow"}, 32'(overflow), 32'(eov));
        check({tag, " busy_low"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, cyc2, seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; carryin = 1'b0; sub = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst sum", 32'(sum), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst carryout", 32'(carryout), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run16("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run16("addwrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("addovf",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Reset two cycles into RUN aborts the operation.
        a = 16'h1111; b = 16'h2222; carryin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort sum", 32'(sum), 32'd0);
        check("abort overflow", 32'(overflow), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort no_done", 32'(seen), 32'd0);
        run16("addA5", 16'h000A, 16'h0005, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0);

        // start held high: second operation accepted in DONE.
        a = 16'h0001; b = 16'h0001; carryin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h00FF; b = 16'h0001;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b first latency", 32'(cyc), 32'd4);
        check("b2b first sum", 32'(sum), 32'h0002);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b rerun busy", 32'(busy), 32'd1);
        cyc2 = 1;
        while (!done && cyc2 < 20) begin
            @(posedge clk); #1;
            cyc2++;
        end
        check("b2b spacing", 32'(cyc2), 32'd5);
        check("b2b second sum", 32'(sum), 32'h0100);
        @(posedge clk); #1;

`ifdef ADDSUB_EN
        run16("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run16("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        // Single-digit instance: done one cycle after start.
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("d8 busy", 32'(busy8), 32'd1);
        @(posedge clk); #1;
        check("d8 done", 32'(done8), 32'd1);
        check("d8 sum", 32'(sum8), 32'h00);
        check("d8 carryout", 32'(co8), 32'd1);
        check("d8 overflow", 32'(ov8), 32'd0);
        @(posedge clk); #1;
        check("d8 done_pulse", 32'(done8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
